decode_queue: RTL and testbench
===============================

DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC/immediate width.
REQ-002 SHALL have parameter DEPTH, default 2, decoded-bundle queue entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  fetch offers an instruction.
REQ-006 SHALL have port in_ready  output  1  queue accepts this cycle.
REQ-007 SHALL have port inst_i  input  32  raw instruction.
REQ-008 SHALL have port pc_i  input  XLEN  instruction PC.
REQ-009 SHALL have port flush  input  1  discard all queued and offered entries.
REQ-010 SHALL have port out_valid  output  1  head entry valid.
REQ-011 SHALL have port out_ready  input  1  execute consumes the head.
REQ-012 SHALL have port bundle_o  output  struct  head fields: jal, jalr, branch, mem_to_reg, load_npc, reg_write[2:0], mem_write[3:0], alu_ctrl[4:0], alu_src1, alu_src2[1:0], imm_type[2:0], imm[XLEN-1:0], rs1/rs2/rd[4:0], pc[XLEN-1:0], illegal.

Function
REQ-013 SHALL decode inst_i combinationally at entry, store the bundle on push; queue holds decoded bundles, not raw words.
REQ-014 SHALL push when in_valid && in_ready && !flush; pop when out_valid && out_ready.
REQ-015 SHALL drive in_ready = (count < DEPTH) || out_ready (pop frees a slot for same-cycle push).
REQ-016 SHALL give latency 1: instruction pushed at edge N on an empty queue shows out_valid=1 after edge N.
REQ-017 SHALL keep FIFO order; pointers wrap modulo DEPTH; count in 0..DEPTH.
REQ-018 SHALL hold bundle_o stable while out_valid && !out_ready.
REQ-019 SHALL, on flush, set count=0 and pointers equal at next edge; flush beats simultaneous push and pop.
REQ-020 SHALL decode RV32I: OP-IMM, OP, LOAD, STORE, LUI, AUIPC, JAL, JALR, BRANCH with the team's standard control encodings.
REQ-021 SHALL produce imm sign-extended to XLEN per I/S/B/U/J type.
REQ-022 SHALL set illegal=1 for: unknown opcode; LOAD fn3 011/110/111; STORE fn3 >010; BRANCH fn3 010/011; OP fn7 not 0000000/0100000 (except REQ-028); shift-immediate fn7 invalid.
REQ-023 SHALL, when illegal=1, force reg_write=NOREGWRITE, mem_write=0000, jal=jalr=branch=0.
REQ-024 SHALL drive bundle_o all-zero whenever out_valid=0.

Reset
REQ-025 SHALL, on rst, clear count, pointers and out_valid asynchronously; in_ready=1 while rst low and queue empty.
REQ-026 SHALL drop in-flight entries if rst asserts mid-operation; no entry survives reset.

Configuration
REQ-027 SHALL compile RV32M decode only when macro RV32M_DECODE_EN is defined.
REQ-028 SHALL, with RV32M_DECODE_EN, map OP fn7=0000001 fn3 000..111 to MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU alu_ctrl codes, illegal=0; without it those encodings set illegal=1.

Structure
REQ-029 SHALL place reg_write, imm_type, alu_ctrl encodings (incl. M codes) and the bundle typedef in shared package decode_pkg.
REQ-030 SHALL implement decode in combinational sub-module decode_logic; queue storage/pointers in decode_queue.

Verification
REQ-031 0x00500093 (addi x1,x0,5) pushed into empty queue -> next cycle out_valid=1, alu_ctrl=ADD, imm=5, rd=1, reg_write=LW, illegal=0.
REQ-032 0x0020A423 (sw x2,8(x1)) -> mem_write=1111, imm_type=STYPE, imm=8, reg_write=NOREGWRITE.
REQ-033 DEPTH=2, out_ready=0, three pushes -> third stalls with in_ready=0; out_ready=1 -> pop and push same cycle, order preserved.
REQ-034 flush=1 with in_valid=1 and two queued -> next cycle out_valid=0, count=0, offered instruction dropped.
REQ-035 0xFFFFFFFF -> illegal=1, mem_write=0000, reg_write=NOREGWRITE; 0x022081B3 -> ALU MUL, illegal=0 with RV32M_DECODE_EN, illegal=1 without.
REQ-036 rst pulse mid-cycle with queue full -> out_valid=0 immediately, in_ready=1 after release.

Source files
------------

// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decode_pkg
//  Description : Shared encodings, decoded-bundle typedef and immediate helpers
//                for the decode queue.
//  Revision    : 1.0  initial release
// ============================================================================
package decode_pkg;

    localparam int PKG_XLEN = 32;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic       SRC1_RS1 = 1'b0;
    localparam logic       SRC1_PC  = 1'b1;
    localparam logic [1:0] SRC2_RS2 = 2'd0;
    localparam logic [1:0] SRC2_IMM = 2'd1;

    // Register write-back width; LW also covers every full-word ALU result
    typedef enum logic [2:0] {
        NOREGWRITE = 3'd0,
        LB         = 3'd1,
        LH         = 3'd2,
        LW         = 3'd3,
        LBU        = 3'd4,
        LHU        = 3'd5
    } reg_write_e;

    typedef enum logic [2:0] {
        NOIMM = 3'd0,
        ITYPE = 3'd1,
        STYPE = 3'd2,
        BTYPE = 3'd3,
        UTYPE = 3'd4,
        JTYPE = 3'd5
    } imm_type_e;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_BEQ    = 5'd10,
        ALU_BNE    = 5'd11,
        ALU_BLT    = 5'd12,
        ALU_BGE    = 5'd13,
        ALU_BLTU   = 5'd14,
        ALU_BGEU   = 5'd15,
        ALU_COPYB  = 5'd16,
        ALU_MUL    = 5'd24,
        ALU_MULH   = 5'd25,
        ALU_MULHSU = 5'd26,
        ALU_MULHU  = 5'd27,
        ALU_DIV    = 5'd28,
        ALU_DIVU   = 5'd29,
        ALU_REM    = 5'd30,
        ALU_REMU   = 5'd31
    } alu_ctrl_e;

    typedef struct packed {
        logic                jal;
        logic                jalr;
        logic                branch;
        logic                mem_to_reg;
        logic                load_npc;
        reg_write_e          reg_write;
        logic [3:0]          mem_write;
        alu_ctrl_e           alu_ctrl;
        logic                alu_src1;
        logic [1:0]          alu_src2;
        imm_type_e           imm_type;
        logic [PKG_XLEN-1:0] imm;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [PKG_XLEN-1:0] pc;
        logic                illegal;
    } bundle_t;

    // Integer ALU op selected by funct3; alt picks SUB/SRA over ADD/SRL
    function automatic alu_ctrl_e alu_base(input logic [2:0] fn3, input logic alt);
        case (fn3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [PKG_XLEN-1:0] sext_imm(input logic [31:0] inst,
                                                     input imm_type_e   kind);
        logic [31:0] v;
        case (kind)
            ITYPE:   v = {{20{inst[31]}}, inst[31:20]};
            STYPE:   v = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            BTYPE:   v = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            UTYPE:   v = {inst[31:12], 12'b0};
            JTYPE:   v = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: v = 32'b0;
        endcase
        return {{(PKG_XLEN-31){v[31]}}, v[30:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : decode_queue_if
//  Description : Fetch-side and execute-side handshake bundle of decode_queue.
//  Revision    : 1.0  initial release
// ============================================================================
interface decode_queue_if #(parameter int XLEN = decode_pkg::PKG_XLEN);
    import decode_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     inst_i;
    logic [XLEN-1:0] pc_i;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    bundle_t         bundle_o;

    modport master (
        output in_valid, inst_i, pc_i, flush, out_ready,
        input  in_ready, out_valid, bundle_o
    );

    modport slave (
        input  in_valid, inst_i, pc_i, flush, out_ready,
        output in_ready, out_valid, bundle_o
    );
endinterface
`default_nettype wire

// File: rtl/decode_logic.sv
`default_nettype none
// ============================================================================
//  Module      : decode_logic
//  Description : Combinational RV32I decoder producing one bundle_t.
//                Macro RV32M_DECODE_EN adds RV32M (OP, funct7=0000001) decode.
//  Revision    : 1.0  initial release
// ============================================================================
module decode_logic
    import decode_pkg::*;
#(
    parameter int XLEN = PKG_XLEN
) (
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    output bundle_t         bundle
);

    logic [6:0] w_opcode;
    logic [2:0] w_fn3;
    logic [6:0] w_fn7;
    bundle_t    w_b;
    logic       w_legal;

    assign w_opcode = inst[6:0];
    assign w_fn3    = inst[14:12];
    assign w_fn7    = inst[31:25];

    always_comb begin
        w_b       = '0;
        w_legal   = 1'b1;
        w_b.pc    = pc;
        w_b.rs1   = inst[19:15];
        w_b.rs2   = inst[24:20];
        w_b.rd    = inst[11:7];
        case (w_opcode)
            OPC_OP_IMM: begin
                w_b.imm_type  = ITYPE;
                w_b.reg_write = LW;
                w_b.alu_src2  = SRC2_IMM;
                w_b.alu_ctrl  = alu_base(w_fn3, (w_fn3 == 3'b101) && inst[30]);
                if (w_fn3 == 3'b001 && w_fn7 != 7'b0000000)
                    w_legal = 1'b0;
                if (w_fn3 == 3'b101 && w_fn7 != 7'b0000000 && w_fn7 != 7'b0100000)
                    w_legal = 1'b0;
            end
            OPC_OP: begin
                w_b.reg_write = LW;
                w_b.alu_src2  = SRC2_RS2;
                if (w_fn7 == 7'b0000000 || w_fn7 == 7'b0100000) begin
                    w_b.alu_ctrl = alu_base(w_fn3, w_fn7[5]);
`ifdef RV32M_DECODE_EN
                end else if (w_fn7 == 7'b0000001) begin
                    case (w_fn3)
                        3'b000:  w_b.alu_ctrl = ALU_MUL;
                        3'b001:  w_b.alu_ctrl = ALU_MULH;
                        3'b010:  w_b.alu_ctrl = ALU_MULHSU;
                        3'b011:  w_b.alu_ctrl = ALU_MULHU;
                        3'b100:  w_b.alu_ctrl = ALU_DIV;
                        3'b101:  w_b.alu_ctrl = ALU_DIVU;
                        3'b110:  w_b.alu_ctrl = ALU_REM;
                        default: w_b.alu_ctrl = ALU_REMU;
                    endcase
`endif
                end else begin
                    w_legal = 1'b0;
                end
            end
            OPC_LOAD: begin
                w_b.imm_type   = ITYPE;
                w_b.mem_to_reg = 1'b1;
                w_b.alu_src2   = SRC2_IMM;
                case (w_fn3)
                    3'b000:  w_b.reg_write = LB;
                    3'b001:  w_b.reg_write = LH;
                    3'b010:  w_b.reg_write = LW;
                    3'b100:  w_b.reg_write = LBU;
                    3'b101:  w_b.reg_write = LHU;
                    default: w_legal = 1'b0;
                endcase
            end
            OPC_STORE: begin
                w_b.imm_type = STYPE;
                w_b.alu_src2 = SRC2_IMM;
                case (w_fn3)
                    3'b000:  w_b.mem_write = 4'b0001;
                    3'b001:  w_b.mem_write = 4'b0011;
                    3'b010:  w_b.mem_write = 4'b1111;
                    default: w_legal = 1'b0;
                endcase
            end
            OPC_LUI: begin
                w_b.imm_type  = UTYPE;
                w_b.reg_write = LW;
                w_b.alu_ctrl  = ALU_COPYB;
                w_b.alu_src2  = SRC2_IMM;
            end
            OPC_AUIPC: begin
                w_b.imm_type  = UTYPE;
                w_b.reg_write = LW;
                w_b.alu_src1  = SRC1_PC;
                w_b.alu_src2  = SRC2_IMM;
            end
            // ALU forms the jump target; rd receives pc+4 through load_npc
            OPC_JAL: begin
                w_b.imm_type  = JTYPE;
                w_b.reg_write = LW;
                w_b.jal       = 1'b1;
                w_b.load_npc  = 1'b1;
                w_b.alu_src1  = SRC1_PC;
                w_b.alu_src2  = SRC2_IMM;
            end
            OPC_JALR: begin
                w_b.imm_type  = ITYPE;
                w_b.reg_write = LW;
                w_b.jalr      = 1'b1;
                w_b.load_npc  = 1'b1;
                w_b.alu_src2  = SRC2_IMM;
            end
            OPC_BRANCH: begin
                w_b.imm_type = BTYPE;
                w_b.branch   = 1'b1;
                case (w_fn3)
                    3'b000:  w_b.alu_ctrl = ALU_BEQ;
                    3'b001:  w_b.alu_ctrl = ALU_BNE;
                    3'b100:  w_b.alu_ctrl = ALU_BLT;
                    3'b101:  w_b.alu_ctrl = ALU_BGE;
                    3'b110:  w_b.alu_ctrl = ALU_BLTU;
                    3'b111:  w_b.alu_ctrl = ALU_BGEU;
                    default: w_legal = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
        w_b.imm = sext_imm(inst, w_b.imm_type);
        // Illegal words keep only their register fields and PC for trap reporting
        if (!w_legal) begin
            w_b.jal        = 1'b0;
            w_b.jalr       = 1'b0;
            w_b.branch     = 1'b0;
            w_b.mem_to_reg = 1'b0;
            w_b.load_npc   = 1'b0;
            w_b.reg_write  = NOREGWRITE;
            w_b.mem_write  = 4'b0000;
            w_b.alu_ctrl   = ALU_ADD;
            w_b.alu_src1   = SRC1_RS1;
            w_b.alu_src2   = SRC2_RS2;
            w_b.imm_type   = NOIMM;
            w_b.imm        = '0;
        end
        w_b.illegal = !w_legal;
    end

    assign bundle = w_b;

endmodule
`default_nettype wire

// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
//  Module      : decode_queue
//  Description : Decodes fetched instructions on entry and buffers the bundles
//                in a DEPTH-entry FIFO. Optional macro: RV32M_DECODE_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module decode_queue
    import decode_pkg::*;
#(
    parameter int XLEN  = PKG_XLEN,
    parameter int DEPTH = 2
) (
    input  wire logic       clk,
    input  wire logic       rst,
    decode_queue_if.slave   bus
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    bundle_t        w_dec;
    bundle_t        r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [PW:0]    r_count;
    logic           w_push;
    logic           w_pop;
    logic           w_out_valid;

    decode_logic #(.XLEN(XLEN)) u_decode (
        .inst   (bus.inst_i),
        .pc     (bus.pc_i),
        .bundle (w_dec)
    );

    assign w_out_valid  = (r_count != '0);
    assign bus.in_ready = (r_count < (PW+1)'(DEPTH)) || bus.out_ready;
    assign w_push       = bus.in_valid && bus.in_ready && !bus.flush;
    assign w_pop        = w_out_valid && bus.out_ready;

    // Flush overrides any push or pop presented in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_dec;
    end

    assign bus.out_valid = w_out_valid;
    assign bus.bundle_o  = w_out_valid ? r_mem[r_rd_ptr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_decode_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_queue
//  Description : Scoreboard bench for decode_queue with a table-driven decoder
//                model; honours RV32M_DECODE_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_decode_queue;
    import decode_pkg::*;

    localparam int DEPTH = 2;
`ifdef RV32M_DECODE_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    localparam alu_ctrl_e BASE_OPS [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                                           ALU_XOR, ALU_SRL, ALU_OR,  ALU_AND};
    localparam alu_ctrl_e BR_OPS   [8] = '{ALU_BEQ, ALU_BNE, ALU_ADD,  ALU_ADD,
                                           ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};
    localparam reg_write_e LOAD_RW [8] = '{LB, LH, LW, NOREGWRITE,
                                           LBU, LHU, NOREGWRITE, NOREGWRITE};
    localparam logic [6:0] OPS     [9] = '{7'h13, 7'h33, 7'h03, 7'h23, 7'h37,
                                           7'h17, 7'h6F, 7'h67, 7'h63};

    logic        clk = 1'b0;
    logic        rst;
    bundle_t     sb [$];
    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] pc_ctr = 32'h0000_1000;

    always #5 clk = ~clk;

    decode_queue_if #(.XLEN(32)) dq_if ();

    decode_queue #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dq_if.slave)
    );

    function automatic bundle_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        bundle_t e;
        int f3, f7, op, ii, s7, sgn, si, bi, ui, ji;
        bit ok;
        f3  = int'(w[14:12]);
        f7  = int'(w[31:25]);
        op  = int'(w[6:0]);
        ii  = $signed(w) >>> 20;
        s7  = $signed(w) >>> 25;
        sgn = $signed(w) >>> 31;
        si  = s7 * 32 + int'(w[11:7]);
        bi  = sgn * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        ui  = int'(w) - int'(w[11:0]);
        ji  = sgn * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
        ok  = 1'b1;
        e   = '0;
        case (op)
            'h13: begin
                e.imm_type = ITYPE; e.imm = ii; e.reg_write = LW; e.alu_src2 = 2'd1;
                e.alu_ctrl = BASE_OPS[f3];
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) begin
                    ok = (f7 == 0 || f7 == 32);
                    if (f7 == 32) e.alu_ctrl = ALU_SRA;
                end
            end
            'h33: begin
                e.reg_write = LW;
                if (f7 == 0 || f7 == 32) begin
                    e.alu_ctrl = BASE_OPS[f3];
                    if (f7 == 32 && f3 == 0) e.alu_ctrl = ALU_SUB;
                    if (f7 == 32 && f3 == 5) e.alu_ctrl = ALU_SRA;
                end else if (f7 == 1 && M_EN) begin
                    e.alu_ctrl = alu_ctrl_e'(5'(24 + f3));
                end else begin
                    ok = 1'b0;
                end
            end
            'h03: begin
                e.imm_type = ITYPE; e.imm = ii; e.mem_to_reg = 1'b1; e.alu_src2 = 2'd1;
                e.reg_write = LOAD_RW[f3];
                ok = (LOAD_RW[f3] != NOREGWRITE);
            end
            'h23: begin
                e.imm_type = STYPE; e.imm = si; e.alu_src2 = 2'd1;
                ok = (f3 <= 2);
                e.mem_write = 4'((1 << (1 << f3)) - 1);
            end
            'h37: begin
                e.imm_type = UTYPE; e.imm = ui; e.reg_write = LW;
                e.alu_ctrl = ALU_COPYB; e.alu_src2 = 2'd1;
            end
            'h17: begin
                e.imm_type = UTYPE; e.imm = ui; e.reg_write = LW;
                e.alu_src1 = 1'b1; e.alu_src2 = 2'd1;
            end
            'h6F: begin
                e.imm_type = JTYPE; e.imm = ji; e.reg_write = LW; e.jal = 1'b1;
                e.load_npc = 1'b1; e.alu_src1 = 1'b1; e.alu_src2 = 2'd1;
            end
            'h67: begin
                e.imm_type = ITYPE; e.imm = ii; e.reg_write = LW; e.jalr = 1'b1;
                e.load_npc = 1'b1; e.alu_src2 = 2'd1;
            end
            'h63: begin
                e.imm_type = BTYPE; e.imm = bi; e.branch = 1'b1;
                ok = (f3 != 2 && f3 != 3);
                e.alu_ctrl = BR_OPS[f3];
            end
            default: ok = 1'b0;
        endcase
        if (!ok) e = '0;
        e.pc      = pc;
        e.rs1     = w[19:15];
        e.rs2     = w[24:20];
        e.rd      = w[11:7];
        e.illegal = !ok;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    task automatic chk_b(input string name, input bundle_t got, input bundle_t exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Accounts for the edge just passed using the inputs that were applied to it
    task automatic account();
        int sz;
        bit pop, push;
        sz = sb.size();
        if (rst || dq_if.flush) begin
            sb.delete();
        end else begin
            pop  = (sz > 0) && dq_if.out_ready;
            push = dq_if.in_valid && ((sz < DEPTH) || dq_if.out_ready);
            if (pop)  void'(sb.pop_front());
            if (push) sb.push_back(ref_decode(dq_if.inst_i, dq_if.pc_i));
        end
    endtask

    task automatic step(input logic v, input logic [31:0] ins, input logic fl, input logic ordy);
        @(posedge clk);
        #1;
        account();
        #1;
        dq_if.in_valid  = v;
        dq_if.inst_i    = ins;
        dq_if.pc_i      = pc_ctr;
        dq_if.flush     = fl;
        dq_if.out_ready = ordy;
        pc_ctr          = pc_ctr + 32'd4;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] gen_inst();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 9);
        if (k < 9) w[6:0] = OPS[k];
        case ($urandom_range(0, 4))
            0:       w[31:25] = 7'h00;
            1:       w[31:25] = 7'h20;
            2:       w[31:25] = 7'h01;
            default: ;
        endcase
        return w;
    endfunction

    always @(negedge clk) begin
        chk("in_ready", 32'(dq_if.in_ready), 32'((sb.size() < DEPTH) || dq_if.out_ready));
        chk("out_valid", 32'(dq_if.out_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) chk_b("head_bundle", dq_if.bundle_o, sb[0]);
        else                chk_b("idle_bundle_zero", dq_if.bundle_o, '0);
    end

    initial begin
        rst             = 1'b1;
        dq_if.in_valid  = 1'b0;
        dq_if.inst_i    = '0;
        dq_if.pc_i      = '0;
        dq_if.flush     = 1'b0;
        dq_if.out_ready = 1'b0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        rst = 1'b0;
        at_neg();
        chk("reset_out_valid", 32'(dq_if.out_valid), 0);
        chk("reset_in_ready", 32'(dq_if.in_ready), 1);

        // addi x1,x0,5 then sw x2,8(x1) with a same-cycle pop
        step(1, 32'h0050_0093, 0, 0);
        step(0, 0, 0, 0);
        at_neg();
        chk("addi_valid", 32'(dq_if.out_valid), 1);
        chk("addi_alu", 32'(dq_if.bundle_o.alu_ctrl), 32'(ALU_ADD));
        chk("addi_imm", dq_if.bundle_o.imm, 32'd5);
        chk("addi_rd", 32'(dq_if.bundle_o.rd), 1);
        chk("addi_rw", 32'(dq_if.bundle_o.reg_write), 32'(LW));
        chk("addi_illegal", 32'(dq_if.bundle_o.illegal), 0);
        step(1, 32'h0020_A423, 0, 1);
        step(0, 0, 0, 0);
        at_neg();
        chk("sw_mask", 32'(dq_if.bundle_o.mem_write), 32'hF);
        chk("sw_imm_type", 32'(dq_if.bundle_o.imm_type), 32'(STYPE));
        chk("sw_imm", dq_if.bundle_o.imm, 32'd8);
        chk("sw_rw", 32'(dq_if.bundle_o.reg_write), 32'(NOREGWRITE));
        step(0, 0, 0, 1);

        // Fill to DEPTH, third push stalls, then pop and push together
        step(1, 32'h0010_0113, 0, 0);
        step(1, 32'h0020_0193, 0, 0);
        step(1, 32'h0030_0213, 0, 0);
        at_neg();
        chk("full_in_ready", 32'(dq_if.in_ready), 0);
        step(1, 32'h0030_0213, 0, 0);
        step(1, 32'h0030_0213, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Flush with two queued and an offered instruction
        step(1, 32'h0010_0113, 0, 0);
        step(1, 32'h0020_0193, 0, 0);
        step(1, 32'h0030_0213, 1, 1);
        step(0, 0, 0, 0);
        at_neg();
        chk("flush_out_valid", 32'(dq_if.out_valid), 0);

        // Illegal all-ones word, then MUL
        step(1, 32'hFFFF_FFFF, 0, 0);
        step(1, 32'h0220_81B3, 0, 1);
        at_neg();
        chk("ill_flag", 32'(dq_if.bundle_o.illegal), 1);
        chk("ill_mask", 32'(dq_if.bundle_o.mem_write), 0);
        chk("ill_rw", 32'(dq_if.bundle_o.reg_write), 32'(NOREGWRITE));
        step(0, 0, 0, 0);
        at_neg();
        chk("mul_illegal", 32'(dq_if.bundle_o.illegal), M_EN ? 0 : 1);
        chk("mul_alu", 32'(dq_if.bundle_o.alu_ctrl), M_EN ? 32'(ALU_MUL) : 32'(ALU_ADD));
        step(0, 0, 0, 1);

        // Asynchronous reset pulse with a full queue
        step(1, 32'h0010_0113, 0, 0);
        step(1, 32'h0020_0193, 0, 0);
        step(0, 0, 0, 0);
        #1;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("rst_async_out_valid", 32'(dq_if.out_valid), 0);
        step(0, 0, 0, 0);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_release_in_ready", 32'(dq_if.in_ready), 1);
        chk("rst_release_out_valid", 32'(dq_if.out_valid), 0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 3) != 0, gen_inst(), $urandom_range(0, 40) == 0,
                 $urandom_range(0, 3) != 0);
        end
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        at_neg();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
